// File: rtl/safe_key_feeder_pkg.sv
// Shared widths, FSM encoding and the published target key for the safe key feeder.
package safe_pkg;

    localparam int unsigned DATA_W  = 7;
    localparam int unsigned NBEATS  = 8;
    localparam int unsigned STRIDE  = 5;
    localparam int unsigned KEY_W   = 56;
    localparam int unsigned PHASE_W = $clog2(NBEATS);

    localparam logic [KEY_W-1:0] TARGET_KEY = 56'd3008192072309708;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        CHECK,
        DONE
    } state_t;

    typedef logic [DATA_W-1:0] char_t;

    // Character image indexed by checker memory location
    typedef char_t [NBEATS-1:0] image_t;

endpackage

// File: rtl/safe_key_feeder_key_unscramble.sv
// Inverts the checker's bit shuffle: 56-bit shuffled key -> 8-entry character image.
module key_unscramble
    import safe_pkg::*;
(
    input  logic [KEY_W-1:0] i_key,
    output image_t           o_img
);

    logic [KEY_W-1:0] w_magic;

    assign w_magic = {i_key[13:0], i_key[45:26], i_key[25:14], i_key[55:46]};

    // Magic is split MSB-first in the checker's concatenation order 0,5,6,2,4,3,7,1
    assign o_img[0] = w_magic[55:49];
    assign o_img[5] = w_magic[48:42];
    assign o_img[6] = w_magic[41:35];
    assign o_img[2] = w_magic[34:28];
    assign o_img[4] = w_magic[27:21];
    assign o_img[3] = w_magic[20:14];
    assign o_img[7] = w_magic[13:7];
    assign o_img[1] = w_magic[6:0];

endmodule

// File: rtl/safe_key_feeder.sv
// Streams an unscrambled key image into the safe checker in its stride-5 write order
// and captures the checker's open_safe verdict.
module safe_key_feeder
    import safe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KEY_W-1:0]  key,
    input  logic              open_safe,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    localparam int unsigned BEAT_W = $clog2(NBEATS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PHASE_W-1:0]  r_phase;
    logic [PHASE_W-1:0]  w_phase_nxt;
    logic [BEAT_W-1:0]   r_beat;
    logic [BEAT_W-1:0]   w_beat_nxt;
    image_t              r_img;
    image_t              w_img_nxt;
    image_t              w_key_img;
    logic                r_pass;
    logic                w_pass_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                r_busy;
    logic                r_done;

    key_unscramble u_key_unscramble (
        .i_key (key),
        .o_img (w_key_img)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_beat  <= '0;
            r_img   <= '0;
            r_pass  <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_beat  <= w_beat_nxt;
            r_img   <= w_img_nxt;
            r_pass  <= w_pass_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= (w_state_nxt == SEND) || (w_state_nxt == CHECK);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // Next-state logic; data is pre-computed for the phase the checker will hold next cycle
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_img_nxt   = r_img;
        w_pass_nxt  = r_pass;
        w_phase_nxt = r_phase + PHASE_W'(STRIDE);

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = SEND;
                    w_img_nxt   = w_key_img;
                    w_beat_nxt  = '0;
                    w_pass_nxt  = 1'b0;
                end
            end
            SEND: begin
                w_beat_nxt = r_beat + BEAT_W'(1);
                if (r_beat == BEAT_W'(NBEATS - 1)) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                w_pass_nxt  = open_safe;
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_data_nxt = (w_state_nxt == IDLE) ? '0 : w_img_nxt[w_phase_nxt];
    end

    assign data = r_data;
    assign busy = r_busy;
    assign done = r_done;
    assign pass = r_pass;

endmodule
